// File: rtl/countdown_display_driver.sv
// countdown_display_driver: captures a binary value through a valid/busy
// handshake, converts it to four BCD digits with a sequential shift-add-3
// engine, and time-multiplexes the digits onto a 7-segment display.
module countdown_display_driver #(
  parameter int unsigned VAL_W       = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic [VAL_W-1:0] value_in,
  input  logic             value_valid,
  input  logic             blank_lz,
  output logic             busy,
  output logic [3:0]       an,
  output logic [7:0]       seg
);

  localparam int unsigned CNT_W     = $clog2(VAL_W + 1);
  localparam int unsigned PRE_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [7:0]  SEG_ZERO  = 8'b00000011;
  localparam logic [3:0]  AN_ONES   = 4'b1000;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t           r_state;
  logic [VAL_W-1:0] r_bin;
  logic [15:0]      r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_disp;
  logic             r_busy;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_idx;
  logic [3:0]       r_an;
  logic [7:0]       r_seg;

  logic [15:0]      w_bcd_adj;
  logic [15:0]      w_bcd_next;
  logic             w_pre_wrap;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [3:0]       w_an;
  logic [7:0]       w_seg;

  // Active-low segment pattern {a,b,c,d,e,f,g,dp}; dp always off
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b00000011;
      4'd1:    s = 8'b10011111;
      4'd2:    s = 8'b00100101;
      4'd3:    s = 8'b00001101;
      4'd4:    s = 8'b10011001;
      4'd5:    s = 8'b01001001;
      4'd6:    s = 8'b01000001;
      4'd7:    s = 8'b00011111;
      4'd8:    s = 8'b00000001;
      4'd9:    s = 8'b00001001;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction on every BCD nibble that is >= 5
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  // One step of {bcd, bin} << 1 after correction
  assign w_bcd_next = (w_bcd_adj << 1) | 16'(r_bin[VAL_W-1]);

  // Conversion FSM; displayed register only loads on the final shift
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_disp  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (value_valid && !r_busy) begin
            r_bin   <= value_in;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(VAL_W);
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd <= w_bcd_next;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_disp  <= w_bcd_next;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_pre_wrap = (r_pre == PRE_W'(REFRESH_DIV - 1));

  // Free-running slot prescaler and digit scan index
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= 2'd0;
    end else if (w_pre_wrap) begin
      r_pre <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Select the scanned digit and decide leading-zero blanking
  always_comb begin
    w_digit = r_disp[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_digit = r_disp[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = r_disp[7:4];
        w_blank = blank_lz && (r_disp[15:4] == 12'd0);
      end
      2'd2: begin
        w_digit = r_disp[11:8];
        w_blank = blank_lz && (r_disp[15:8] == 8'd0);
      end
      default: begin
        w_digit = r_disp[15:12];
        w_blank = blank_lz && (r_disp[15:12] == 4'd0);
      end
    endcase
    w_an  = w_blank ? 4'b0000 : (AN_ONES >> r_idx);
    w_seg = w_blank ? SEG_BLANK : seg_of(w_digit);
  end

  // Registered display outputs
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_an  <= AN_ONES;
      r_seg <= SEG_ZERO;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign busy = r_busy;
  assign an   = r_an;
  assign seg  = r_seg;

endmodule

// File: tb/tb_countdown_display_driver.sv
// Bench for countdown_display_driver: directed scenarios followed by random
// traffic, every cycle compared against a decimal-arithmetic display model.
module tb_countdown_display_driver;

  localparam int unsigned VAL_W       = 8;
  localparam int unsigned REFRESH_DIV = 4;

  logic             clk1 = 1'b0;
  logic             reset;
  logic [VAL_W-1:0] value_in;
  logic             value_valid;
  logic             blank_lz;
  logic             busy;
  logic [3:0]       an;
  logic [7:0]       seg;

  int total = 0;
  int bad   = 0;

  countdown_display_driver #(
    .VAL_W       (VAL_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk1        (clk1),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .blank_lz    (blank_lz),
    .busy        (busy),
    .an          (an),
    .seg         (seg)
  );

  always #5 clk1 = ~clk1;

  logic [7:0] seg_tab [10] = '{8'b00000011, 8'b10011111, 8'b00100101,
                              8'b00001101, 8'b10011001, 8'b01001001,
                              8'b01000001, 8'b00011111, 8'b00000001,
                              8'b00001001};
  int p10 [4] = '{1, 10, 100, 1000};

  // Model state: edges since reset, display contents, pending conversion
  int n        = 0;
  int disp_reg = 0;
  int vis      = 0;
  int pend     = 0;
  int done     = 0;
  bit busy_m   = 1'b0;
  bit blz_used = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare on the falling edge
  task automatic step(input bit rst, input bit vv, input int val, input bit blz);
    bit          was;
    int          slot;
    bit          blank;
    logic [3:0]  e_an;
    logic [7:0]  e_seg;
    reset       = rst;
    value_valid = vv;
    value_in    = VAL_W'(val);
    blank_lz    = blz;
    @(posedge clk1);
    if (rst) begin
      n        = 0;
      disp_reg = 0;
      vis      = 0;
      busy_m   = 1'b0;
      blz_used = 1'b0;
    end else begin
      n++;
      vis      = disp_reg;
      blz_used = blz;
      was      = busy_m;
      if (busy_m && n == done) begin
        disp_reg = pend;
        busy_m   = 1'b0;
      end
      if (!was && vv) begin
        pend   = val;
        busy_m = 1'b1;
        done   = n + VAL_W;
      end
    end
    slot  = (n == 0) ? 0 : ((n - 1) / REFRESH_DIV) % 4;
    blank = (slot > 0) && blz_used && (vis < p10[slot]);
    e_an  = blank ? 4'b0000 : (4'b1000 >> slot);
    e_seg = blank ? 8'hFF : seg_tab[(vis / p10[slot]) % 10];
    @(negedge clk1);
    chk("busy", 32'(busy), 32'(busy_m));
    chk("an",   32'(an),   32'(e_an));
    chk("seg",  32'(seg),  32'(e_seg));
  endtask

  task automatic idle(input int cycles, input bit blz);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, blz);
  endtask

  initial begin
    bit blz_r;
    reset       = 1'b1;
    value_valid = 1'b0;
    value_in    = '0;
    blank_lz    = 1'b0;

    // Reset then a full frame of zeros
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    idle(20, 1'b0);

    // 15 with leading-zero blanking
    step(1'b0, 1'b1, 15, 1'b1);
    idle(30, 1'b1);

    // 255 without blanking
    step(1'b0, 1'b1, 255, 1'b0);
    idle(30, 1'b0);

    // 0 with blanking: only ones lit
    step(1'b0, 1'b1, 0, 1'b1);
    idle(30, 1'b1);

    // 200 captured, 37 dropped while busy
    step(1'b0, 1'b1, 200, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 37, 1'b0);
    idle(30, 1'b0);

    // valid on the completion edge is dropped
    step(1'b0, 1'b1, 123, 1'b0);
    idle(7, 1'b0);
    step(1'b0, 1'b1, 45, 1'b0);
    idle(20, 1'b0);

    // Reset three cycles into converting 99
    step(1'b0, 1'b1, 99, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    idle(30, 1'b0);

    // Random traffic
    blz_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) blz_r = ~blz_r;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 255)), blz_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_display_driver.md
Name: countdown_display_driver

Overview:
- Downstream display stage for the traffic light controller.
- Accepts a binary countdown value through a valid/busy handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes four digits onto the board's 7-segment display, with optional leading-zero blanking.
- Replaces ad-hoc %/÷ display logic with a registered, glitch-free scan driver.

Parameters:
- VAL_W, 8: width of value_in. Legal range 1..13; the maximum value must be ≤ 9999.
- REFRESH_DIV, 100000: clk1 cycles per digit slot. Minimum 2.

Ports:
- clk1  input  1  system clock
- reset  input  1  synchronous active-high reset
- value_in  input  VAL_W  binary value to display, unsigned
- value_valid  input  1  value_in is presented this cycle
- blank_lz  input  1  1 = blank leading zeros (the ones digit is never blanked)
- busy  output  1  conversion in progress; new values are ignored while high
- an  output  4  digit enable, one-hot, active-high
  - an[3] = ones, an[2] = tens, an[1] = hundreds, an[0] = thousands
- seg  output  8  segments, active-low, {a,b,c,d,e,f,g,dp}

Behaviour:
- Single clock domain (clk1). Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - busy = 0
  - displayed BCD register = 0000
  - prescaler = 0, scan index = 0
  - an = 4'b1000, seg = 8'b00000011 (digit 0)
- Handshake:
  - Capture occurs on an edge where value_valid = 1 and busy = 0.
  - value_valid while busy = 1 is dropped. There is no queue and no error flag.
  - value_in is sampled only on the capture edge.
- Conversion FSM, with states IDLE → SHIFT → IDLE:
  - IDLE: on capture, load the shift register with value_in, clear the BCD scratch, set the shift counter to VAL_W, and go to SHIFT. busy rises the following cycle.
  - SHIFT: each cycle, add 3 to every BCD nibble that is ≥ 5, then shift {bcd, bin} left by 1 and decrement the counter.
  - Exit: on the edge completing the last shift, copy the scratch to the displayed register atomically, go to IDLE, and deassert busy.
  - Timing: busy is high for exactly VAL_W cycles. The new digits are visible on seg from the next scan-slot update after busy falls.
- Displayed register: updates only at conversion completion. The display never shows partial results.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, the scan index advances 0→1→2→3→0.
  - an/seg are registered from the scan index and displayed register, so they take 1 cycle of latency after an index change.
  - Each digit is active for exactly REFRESH_DIV cycles; the full frame is 4·REFRESH_DIV cycles.
  - The scan runs continuously, independent of busy.
- Segment encoding, seg for digits 0–9:
  - 0 = 00000011, 1 = 10011111, 2 = 00100101, 3 = 00001101, 4 = 10011001
  - 5 = 01001001, 6 = 01000001, 7 = 00011111, 8 = 00000001, 9 = 00001001
  - dp is always off (1).
- Blanking:
  - With blank_lz = 1, digit k > 0 is blanked when that digit and all higher digits are 0.
  - A blanked slot drives an = 4'b0000 and seg = 8'hFF for its full slot duration; scan timing is unchanged.
  - With blank_lz = 0, all four digits are always shown.
  - blank_lz is sampled each cycle, so a change takes effect on the next registered update.
- Reset mid-conversion: the conversion is aborted. The reset values apply on the next cycle and no stale update follows.
- Simultaneous value_valid and completion edge: busy is still 1 on that edge, so the value is dropped.

Test Plan:
(Benches use REFRESH_DIV = 4, VAL_W = 8.)
- Reset held 2 cycles, then released → busy = 0, an = 1000, seg = 00000011. an steps 1000→0100→0010→0001 every 4 cycles, showing 0 on every digit (blank_lz = 0).
- value_in = 15, valid for 1 cycle, blank_lz = 1 → busy high for exactly 8 cycles. The scan then shows an = 1000/seg = 01001001 and an = 0100/seg = 10011111; the hundreds and thousands slots show an = 0000, seg = FF.
- value_in = 255, blank_lz = 0 → slots show 5, 5, 2, 0 (seg = 01001001, 01001001, 00100101, 00000011).
- value_in = 0, blank_lz = 1 → only the ones slot is lit with seg = 00000011; the other three slots are an = 0000.
- value_in = 200 captured, then value_in = 37 valid 2 cycles later → 37 is dropped, the display shows 0,0,2,0, and busy falls 8 cycles after the 200 capture.
- Reset asserted 3 cycles into converting 99 → next cycle busy = 0 and the display reads 0000. No update to 99 ever occurs.
